// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command/register controller.
// Contents: controller state enum, command read-flag bit position and the
// byte presented on MISO while no frame is active.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    WRITE    = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    READ     = 3'd5
  } spi_cmd_state_e;

  localparam int          SPI_CMD_RD_BIT = 7;
  localparam logic [7:0]  SPI_IDLE_TX    = 8'h00;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Bundle of the frame/byte handshake from the SPI slave front end, the
// MISO byte returned to it, the register bus and the status outputs.
//   slave  modport : the controller (consumes frame/byte events, drives bus)
//   master modport : the environment (SPI front end + register file)
interface spi_cmd_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              frame_start;
  logic              frame_end;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_byte;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              busy;
  logic              ovr_err;
  logic [7:0]        frame_bytes;

  modport slave (
    input  frame_start, frame_end, rx_valid, rx_byte, reg_rdata,
    output tx_byte, reg_addr, reg_wdata, reg_we, reg_re, busy, ovr_err,
           frame_bytes
  );

  modport master (
    output frame_start, frame_end, rx_valid, rx_byte, reg_rdata,
    input  tx_byte, reg_addr, reg_wdata, reg_we, reg_re, busy, ovr_err,
           frame_bytes
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI command/register controller.
// Parses each SSEL-delimited frame as a command byte followed by data bytes.
// Command bit 7 selects read (1) or write (0); the low ADDR_W bits give the
// start address, which auto-increments (wrapping) per data byte. Writes issue
// one reg_we per received data byte. Reads prefetch one register per byte so
// that the next MISO byte is ready: STATUS_BYTE first, then read data.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : spi_cmd_ctrl_if.slave (frame/byte events in, tx_byte out,
//           register bus, busy / ovr_err / frame_bytes status)
// ADDR_W of this module must match the ADDR_W of the connected interface.
module spi_cmd_ctrl
  import spi_pkg::*;
#(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] STATUS_BYTE = 8'h05
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_cmd_ctrl_if.slave  bus
);

  spi_cmd_state_e    state;
  logic [ADDR_W-1:0] addr;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] n);
    return (n == 8'hFF) ? n : n + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      addr            <= '0;
      bus.tx_byte     <= SPI_IDLE_TX;
      bus.reg_addr    <= '0;
      bus.reg_wdata   <= '0;
      bus.reg_we      <= 1'b0;
      bus.reg_re      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.ovr_err     <= 1'b0;
      bus.frame_bytes <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      bus.reg_we <= 1'b0;
      bus.reg_re <= 1'b0;

      // Byte count; a frame_start in the same cycle overrides it below.
      if (bus.rx_valid && state != IDLE)
        bus.frame_bytes <= sat_inc(bus.frame_bytes);

      if (bus.frame_end) begin
        // A byte arriving with frame_end is still honoured if it is write
        // data; a read it would have triggered is dropped with the frame.
        if (bus.rx_valid && state == WRITE) begin
          bus.reg_we    <= 1'b1;
          bus.reg_wdata <= bus.rx_byte;
          bus.reg_addr  <= addr;
          addr          <= addr_inc(addr);
        end
        if (bus.rx_valid && (state == RD_ISSUE || state == RD_WAIT))
          bus.ovr_err <= 1'b1;
        state       <= IDLE;
        bus.busy    <= 1'b0;
        bus.tx_byte <= SPI_IDLE_TX;
      end else if (bus.frame_start) begin
        // Entering CMD from any state, including an abort mid-sequence.
        state           <= CMD;
        bus.busy        <= 1'b1;
        bus.tx_byte     <= STATUS_BYTE;
        bus.frame_bytes <= '0;
        bus.ovr_err     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;

          CMD: begin
            if (bus.rx_valid) begin
              addr <= bus.rx_byte[ADDR_W-1:0];
              if (bus.rx_byte[SPI_CMD_RD_BIT]) begin
                // Fetch the first register straight from the command byte
                // so its data is ready as the byte after STATUS_BYTE.
                state        <= RD_ISSUE;
                bus.reg_re   <= 1'b1;
                bus.reg_addr <= bus.rx_byte[ADDR_W-1:0];
              end else begin
                state <= WRITE;
              end
            end
          end

          WRITE: begin
            if (bus.rx_valid) begin
              bus.reg_we    <= 1'b1;
              bus.reg_wdata <= bus.rx_byte;
              bus.reg_addr  <= addr;
              addr          <= addr_inc(addr);
            end
          end

          // reg_re is high during this state; rdata arrives next cycle.
          RD_ISSUE: begin
            if (bus.rx_valid)
              bus.ovr_err <= 1'b1;
            state <= RD_WAIT;
          end

          RD_WAIT: begin
            if (bus.rx_valid)
              bus.ovr_err <= 1'b1;
            bus.tx_byte <= bus.reg_rdata;
            addr        <= addr_inc(addr);
            state       <= READ;
          end

          // The master's byte is a dummy; it only paces the next prefetch.
          READ: begin
            if (bus.rx_valid) begin
              state        <= RD_ISSUE;
              bus.reg_re   <= 1'b1;
              bus.reg_addr <= addr;
            end
          end

          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
